pwm_bank: RTL and testbench

//  N-channel PWM generator; successor to the single-channel pwm used for LED drive.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_channel.sv | 144 ++++++++++++++
 rtl/pwm_bank.sv | 63 ++++++
 tb/tb_pwm_bank.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the PWM bank.
//   pwm_mode_e : EDGE (sawtooth count) or CENTER (triangle count)
//   pwm_dir_e  : counting direction of a channel counter
//   pwm_cfg_t  : software-facing config record at the default counter width
//   chan_w()   : channel-select width, at least one bit
package pwm_pkg;

    localparam int PWM_CNT_W = 12;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

    typedef struct packed {
        logic [PWM_CNT_W-1:0] duty;
        logic [PWM_CNT_W-1:0] period;
        pwm_mode_e            mode;
    } pwm_cfg_t;

    function automatic int chan_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with double-buffered configuration.
//   clk_i, reset_ni           clock, synchronous active-low reset
//   enable_ni                 active-low run enable
//   wr_i                      accepted config write for this channel
//   duty_i/period_i/mode_i    config payload captured into the shadow regs
//   pend_o                    shadow holds a write not yet applied
//   pwm_o, period_end_o       registered PWM output and boundary pulse
//
// state    | meaning
// DIR_UP   | counting up 0..P (the only state used in EDGE mode)
// DIR_DOWN | CENTER mode, counting down P-1..1
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W        = 12,
    parameter int RESET_PERIOD = 4095
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             enable_ni,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [CNT_W-1:0] period_i,
    input  pwm_mode_e        mode_i,
    output logic             pend_o,
    output logic             pwm_o,
    output logic             period_end_o
);

    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    pwm_mode_e        mode_q, mode_d;
    logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    pwm_mode_e        sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwm_dir_e         dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic             pe_q, pe_d;

    logic edge_like;
    logic boundary;
    logic load;

    // A triangle with P<=1 degenerates, so it runs as a plain sawtooth.
    assign edge_like = (mode_q == PWM_EDGE) || (period_q <= CNT_W'(1));

    always_comb begin
        boundary = 1'b0;
        if (edge_like) begin
            boundary = (cnt_q == period_q);
        end else begin
            boundary = (dir_q == DIR_DOWN) && (cnt_q == CNT_W'(1));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        load  = 1'b0;
        if (enable_ni || boundary) begin
            // While disabled every cycle counts as a boundary for shadow loading.
            cnt_d = '0;
            dir_d = DIR_UP;
            load  = pend_q;
        end else begin
            case (dir_q)
                DIR_UP: begin
                    if (!edge_like && (cnt_q == period_q)) begin
                        dir_d = DIR_DOWN;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DIR_DOWN: cnt_d = cnt_q - CNT_W'(1);
                default: begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                end
            endcase
        end
    end

    always_comb begin
        duty_d      = duty_q;
        period_d    = period_q;
        mode_d      = mode_q;
        sh_duty_d   = sh_duty_q;
        sh_period_d = sh_period_q;
        sh_mode_d   = sh_mode_q;
        pend_d      = pend_q;
        if (load) begin
            duty_d   = sh_duty_q;
            period_d = sh_period_q;
            mode_d   = sh_mode_q;
            pend_d   = 1'b0;
        end
        // A write is only accepted with pend clear, so it never collides with a load;
        // a write taken in a boundary cycle therefore waits for the next boundary.
        if (wr_i) begin
            sh_duty_d   = duty_i;
            sh_period_d = period_i;
            sh_mode_d   = mode_i;
            pend_d      = 1'b1;
        end
        pwm_d = !enable_ni && (cnt_q < duty_q);
        pe_d  = !enable_ni && boundary;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            duty_q      <= '0;
            period_q    <= CNT_W'(RESET_PERIOD);
            mode_q      <= PWM_EDGE;
            sh_duty_q   <= '0;
            sh_period_q <= CNT_W'(RESET_PERIOD);
            sh_mode_q   <= PWM_EDGE;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= DIR_UP;
            pwm_q       <= 1'b0;
            pe_q        <= 1'b0;
        end else begin
            duty_q      <= duty_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            sh_duty_q   <= sh_duty_d;
            sh_period_q <= sh_period_d;
            sh_mode_q   <= sh_mode_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            pwm_q       <= pwm_d;
            pe_q        <= pe_d;
        end
    end

    assign pend_o       = pend_q;
    assign pwm_o        = pwm_q;
    assign period_end_o = pe_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CHANNELS independent PWM channels sharing one config write port.
//   clk_i, reset_ni    clock, synchronous active-low reset
//   enable_ni          active-low run enable for all channels
//   cfg_valid_i/cfg_ready_o  config handshake; ready drops while the target channel
//                            still holds an unapplied write
//   cfg_chan_i         target channel; out-of-range writes are accepted and dropped
//   cfg_duty_i, cfg_period_i, cfg_mode_i  config payload
//   pwm_o, period_end_o  per-channel registered outputs
module pwm_bank
    import pwm_pkg::*;
#(
    parameter  int CHANNELS     = 2,
    parameter  int CNT_W        = 12,
    parameter  int RESET_PERIOD = 4095,
    localparam int CHAN_W       = chan_w(CHANNELS)
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                enable_ni,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [CHAN_W-1:0]   cfg_chan_i,
    input  logic [CNT_W-1:0]    cfg_duty_i,
    input  logic [CNT_W-1:0]    cfg_period_i,
    input  logic                cfg_mode_i,
    output logic [CHANNELS-1:0] pwm_o,
    output logic [CHANNELS-1:0] period_end_o
);

    logic [CHANNELS-1:0] pend;
    logic                pend_sel;
    logic                accept;

    // Channels outside the bank never report pending, so writes to them complete.
    always_comb begin
        pend_sel = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan_i == CHAN_W'(i)) pend_sel = pend[i];
        end
    end

    assign cfg_ready_o = reset_ni && !pend_sel;
    assign accept      = cfg_valid_i && cfg_ready_o;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        pwm_channel #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_chan (
            .clk_i        (clk_i),
            .reset_ni     (reset_ni),
            .enable_ni    (enable_ni),
            .wr_i         (accept && (cfg_chan_i == CHAN_W'(g))),
            .duty_i       (cfg_duty_i),
            .period_i     (cfg_period_i),
            .mode_i       (pwm_mode_e'(cfg_mode_i)),
            .pend_o       (pend[g]),
            .pwm_o        (pwm_o[g]),
            .period_end_o (period_end_o[g])
        );
    end

endmodule

// File: tb/tb_pwm_bank.sv
module tb_pwm_bank;

    localparam int CH  = 3;
    localparam int CW  = 4;
    localparam int RP  = 15;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [1:0]    cfg_chan = '0;
    logic [CW-1:0] cfg_duty = '0;
    logic [CW-1:0] cfg_period = '0;
    logic          cfg_mode = 1'b0;
    logic [CH-1:0] pwm;
    logic [CH-1:0] pe;

    int errors = 0;
    int checks = 0;

    pwm_bank #(.CHANNELS(CH), .CNT_W(CW), .RESET_PERIOD(RP)) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .enable_ni    (en_n),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_chan_i   (cfg_chan),
        .cfg_duty_i   (cfg_duty),
        .cfg_period_i (cfg_period),
        .cfg_mode_i   (cfg_mode),
        .pwm_o        (pwm),
        .period_end_o (pe)
    );

    always #5 clk = ~clk;

    // Reference model: each channel is a phase t within a period of length
    // P+1 (sawtooth) or 2P (triangle); the counter value follows from t.
    int m_duty[CH], m_per[CH], m_mode[CH];
    int s_duty[CH], s_per[CH], s_mode[CH];
    bit m_pend[CH];
    int m_t[CH];
    logic [2*CH-1:0] exp_q[$];
    bit model_on = 0;

    function automatic bit model_ready(input int chan);
        if (!reset_n) return 1'b0;
        if (chan < CH && m_pend[chan]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int period_len(input int p, input int m);
        return (m == 1 && p > 1) ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(input int t, input int p, input int m);
        return (m == 1 && p > 1 && t > p) ? 2 * p - t : t;
    endfunction

    always @(posedge clk) begin
        logic [CH-1:0] ep, ee;
        bit acc;
        int len;
        ep = '0;
        ee = '0;
        acc = cfg_valid && model_ready(int'(cfg_chan));
        for (int c = 0; c < CH; c++) begin
            if (!reset_n) begin
                m_duty[c] = 0; m_per[c] = RP; m_mode[c] = 0;
                m_pend[c] = 0; m_t[c] = 0;
            end else begin
                if (en_n) begin
                    if (m_pend[c]) begin
                        m_duty[c] = s_duty[c]; m_per[c] = s_per[c]; m_mode[c] = s_mode[c];
                        m_pend[c] = 0;
                    end
                    m_t[c] = 0;
                end else begin
                    len = period_len(m_per[c], m_mode[c]);
                    ep[c] = cnt_of(m_t[c], m_per[c], m_mode[c]) < m_duty[c];
                    ee[c] = (m_t[c] == len - 1);
                    if (m_t[c] == len - 1) begin
                        if (m_pend[c]) begin
                            m_duty[c] = s_duty[c]; m_per[c] = s_per[c]; m_mode[c] = s_mode[c];
                            m_pend[c] = 0;
                        end
                        m_t[c] = 0;
                    end else begin
                        m_t[c] = m_t[c] + 1;
                    end
                end
                if (acc && int'(cfg_chan) == c) begin
                    s_duty[c] = int'(cfg_duty); s_per[c] = int'(cfg_period);
                    s_mode[c] = int'(cfg_mode); m_pend[c] = 1;
                end
            end
        end
        exp_q.push_back({ep, ee});
        model_on = 1;
    end

    // Monitor: outputs are presented every cycle; compare against queued model output.
    always @(negedge clk) begin
        logic [2*CH-1:0] e;
        bit r;
        if (model_on) begin
            r = model_ready(int'(cfg_chan));
            checks++;
            if (cfg_ready !== r) begin
                errors++;
                $display("FAIL ready t=%0t chan=%0d: got %b expected %b", $time, cfg_chan, cfg_ready, r);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t: got no expected entry, required one", $time);
            end else begin
                e = exp_q.pop_front();
                if ({pwm, pe} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got pwm=%b pe=%b expected pwm=%b pe=%b",
                             $time, pwm, pe, e[2*CH-1:CH], e[CH-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input int ch, input int d, input int p, input int m);
        int n;
        n = 0;
        @(posedge clk); #2;
        cfg_valid = 1'b1; cfg_chan = 2'(ch);
        cfg_duty = CW'(d); cfg_period = CW'(p); cfg_mode = m[0];
        forever begin
            @(negedge clk);
            if (cfg_ready) break;
            n++;
            if (n > 200) break;
        end
        checks++;
        if (n > 200) begin
            errors++;
            $display("FAIL write_timeout ch=%0d: got ready=0 for 200 clk, required ready=1", ch);
        end
        @(posedge clk); #2;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int ch);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (pe[ch]) break;
            n++;
            if (n > 100) break;
        end
        checks++;
        if (n > 100) begin
            errors++;
            $display("FAIL pulse_timeout ch=%0d: got no period_end in 100 clk, required one", ch);
        end
    endtask

    // Waits two boundaries so the most recent write is active, then records n cycles.
    task automatic sample(input int ch, input int n, output logic [15:0] pw, output logic [15:0] pb);
        pw = '0;
        pb = '0;
        wait_pulse(ch);
        wait_pulse(ch);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pw[i] = pwm[ch];
            pb[i] = pe[ch];
        end
    endtask

    initial begin
        logic [15:0] pw, pb;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;

        // reset defaults: period 16, duty 0
        sample(0, 16, pw, pb);
        chk("reset_pwm_ch0", pw, 16'h0000);
        chk("reset_pe_ch0", pb, 16'h8000);

        do_write(0, 4, 9, 0);
        sample(0, 10, pw, pb);
        chk("edge_pwm_ch0", pw, 16'b0000001111);
        chk("edge_pe_ch0", pb, 16'b1000000000);

        do_write(1, 3, 5, 1);
        sample(1, 10, pw, pb);
        chk("center_pwm_ch1", pw, 16'b1100000111);
        chk("center_pe_ch1", pb, 16'b1000000000);

        // back-to-back to ch2 stalls; other channels and chan=3 stay writable
        do_write(2, 1, 2, 0);
        do_write(2, 7, 3, 1);
        do_write(0, 2, 9, 0);
        do_write(1, 3, 5, 1);
        do_write(3, 5, 5, 1);
        repeat (30) @(posedge clk);

        do_write(0, 0, 7, 0);
        do_write(1, 15, 9, 0);
        sample(1, 10, pw, pb);
        chk("duty_over_p_ch1", pw, 16'h03FF);
        sample(0, 8, pw, pb);
        chk("duty_zero_ch0", pw, 16'h0000);

        // disable mid-period with a pending write, then reset with a pending write
        do_write(2, 5, 12, 0);
        #2 en_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 en_n = 1'b0;
        repeat (30) @(posedge clk);
        do_write(0, 3, 4, 0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        sample(0, 16, pw, pb);
        chk("post_reset_pe_ch0", pb, 16'h8000);

        // randomized traffic; the scoreboard checks every cycle
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #2;
            reset_n    = ($urandom_range(0, 199) != 0);
            en_n       = ($urandom_range(0, 29) == 0);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_chan   = 2'($urandom_range(0, 3));
            cfg_duty   = CW'($urandom_range(0, 15));
            cfg_period = CW'($urandom_range(0, 15));
            cfg_mode   = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #2;
        cfg_valid = 1'b0;
        reset_n = 1'b1;
        en_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
